// File: rtl/us_ranging_scheduler.sv
// rtl/us_ranging_scheduler.sv - round-robin trigger/echo scheduler for up to four ultrasonic range sensors
//
// Ports:
//   clk_50M       system clock (50 MHz)
//   reset         synchronous active-high reset
//   enable        run measurement slots while high
//   echo_rx       asynchronous echo lines, one per sensor
//   trigger       registered trigger lines, at most one high at a time
//   sel           sensor owning the current or next slot
//   meas_valid    one-cycle result strobe (slot's last cycle)
//   meas_idx      sensor index of the result
//   meas_width    echo width in clock cycles
//   meas_timeout  slot ended before the echo pulse finished
//   obst          registered per-sensor obstacle flags
//   state         FSM state encoding

module us_ranging_scheduler #(
  parameter int NUM_SENS    = 3,
  parameter int TRIG_DELAY  = 50,
  parameter int TRIG_LEN    = 500,
  parameter int FRAME_LEN   = 50000,
  parameter int OBST_THRESH = 29410
) (
  input  logic                clk_50M,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_SENS-1:0] echo_rx,
  output logic [NUM_SENS-1:0] trigger,
  output logic [1:0]          sel,
  output logic                meas_valid,
  output logic [1:0]          meas_idx,
  output logic [21:0]         meas_width,
  output logic                meas_timeout,
  output logic [NUM_SENS-1:0] obst,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DELAY     = 3'd1,
    TRIG      = 3'd2,
    WAIT_ECHO = 3'd3,
    MEASURE   = 3'd4,
    HOLD      = 3'd5
  } state_t;

  // DELAY leaves one cycle early so that TRIG (and the trigger register)
  // covers slot cycles TRIG_DELAY .. TRIG_DELAY+TRIG_LEN-1 exactly.
  localparam logic [15:0] TRIG_START  = 16'(TRIG_DELAY - 1);
  localparam logic [15:0] TRIG_END    = 16'(TRIG_DELAY + TRIG_LEN - 1);
  localparam logic [15:0] SLOT_LAST   = 16'(FRAME_LEN - 1);
  // Results are registered one cycle ahead so the strobe lands on the slot's
  // last cycle and reflects the FSM as it stands in that cycle.
  localparam logic [15:0] SLOT_REPORT = 16'(FRAME_LEN - 2);
  localparam logic [21:0] WIDTH_MAX   = '1;
  localparam logic [21:0] THRESH      = 22'(OBST_THRESH);
  localparam logic [1:0]  SEL_LAST    = 2'(NUM_SENS - 1);

  state_t              state_q, state_n;
  logic [15:0]         slot_cnt, slot_cnt_n;
  logic [21:0]         width_cnt, width_n;
  logic [1:0]          sel_n;
  logic [NUM_SENS-1:0] echo_meta, echo_s, echo_d;
  logic [NUM_SENS-1:0] sel_onehot;
  logic [3:0]          echo_s_pad, echo_d_pad;
  logic                echo_cur, echo_rise;
  logic                report, rpt_timeout, rpt_obst;
  logic [21:0]         rpt_width;

  // Pad to four lanes so sel can index any sensor count without
  // out-of-range selects.
  always_comb begin
    echo_s_pad = '0;
    echo_d_pad = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SENS; i++) begin
      echo_s_pad[i] = echo_s[i];
      echo_d_pad[i] = echo_d[i];
      sel_onehot[i] = (sel == 2'(i));
    end
  end

  assign echo_cur = echo_s_pad[sel];
  // A rise needs a low sample first, so an echo already high when
  // WAIT_ECHO is entered is ignored until it drops.
  assign echo_rise = echo_cur && !echo_d_pad[sel];

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    slot_cnt_n = slot_cnt;
    width_n    = width_cnt;
    sel_n      = sel;
    case (state_q)
      IDLE: begin
        slot_cnt_n = '0;
        width_n    = '0;
        if (enable) begin
          state_n = DELAY;
        end
      end
      DELAY: begin
        if (slot_cnt == TRIG_START) begin
          state_n = TRIG;
        end
      end
      TRIG: begin
        if (slot_cnt == TRIG_END) begin
          state_n = WAIT_ECHO;
        end
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_n = MEASURE;
          width_n = 22'd1;
        end
      end
      MEASURE: begin
        if (echo_cur) begin
          if (width_cnt != WIDTH_MAX) begin
            width_n = width_cnt + 22'd1;
          end
        end else begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        state_n = HOLD;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Slot end overrides whatever the per-state logic chose.
    if (state_q != IDLE) begin
      slot_cnt_n = slot_cnt + 16'd1;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt_n = '0;
        width_n    = '0;
        sel_n      = (sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
        state_n    = enable ? DELAY : IDLE;
      end
    end
  end

  assign report      = (state_q != IDLE) && (slot_cnt == SLOT_REPORT);
  assign rpt_timeout = (state_n == WAIT_ECHO) || (state_n == MEASURE);
  assign rpt_width   = (state_n == WAIT_ECHO) ? 22'd0 : width_n;
  assign rpt_obst    = !rpt_timeout && (rpt_width < THRESH);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      slot_cnt     <= '0;
      width_cnt    <= '0;
      sel          <= '0;
      echo_meta    <= '0;
      echo_s       <= '0;
      echo_d       <= '0;
      trigger      <= '0;
      meas_valid   <= 1'b0;
      meas_idx     <= '0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
      obst         <= '0;
    end else begin
      slot_cnt   <= slot_cnt_n;
      width_cnt  <= width_n;
      sel        <= sel_n;
      echo_meta  <= echo_rx;
      echo_s     <= echo_meta;
      echo_d     <= echo_s;
      trigger    <= (state_n == TRIG) ? sel_onehot : '0;
      meas_valid <= report;
      if (report) begin
        meas_idx     <= sel;
        meas_width   <= rpt_width;
        meas_timeout <= rpt_timeout;
        for (int i = 0; i < NUM_SENS; i++) begin
          if (sel_onehot[i]) begin
            obst[i] <= rpt_obst;
          end
        end
      end
    end
  end

  assign state = state_q;

endmodule
